// File: rtl/mem_rmw_adapter_if.sv
// Core load/store channel plus the whole-word memory_map port seen by mem_rmw_adapter.
// slave = adapter view; master = core + memory view.
interface mem_rmw_adapter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_read_data,
    output req_ready, resp_valid, resp_rdata, mem_address, mem_write_data, mem_write_enable
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, mem_address, mem_write_data, mem_write_enable
  );
endinterface

// File: rtl/mem_rmw_adapter.sv
// Load/store adapter: sub-word stores become read-modify-write, so memory only sees whole-word writes.
// Latency: load/partial store READ_LATENCY+1, full store 1; req_ready low while busy, resp has no backpressure.
module mem_rmw_adapter #(
  parameter int READ_LATENCY = 1,
  parameter int RMW_ENABLE   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_rmw_adapter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR} state_t;

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  state_t      state;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  lat_cnt;
  logic        ready_q;
  logic        resp_q;
  logic [3:0]  wen_q;
  logic        go_write;
  logic        is_store;
  logic [31:0] merged;

  // Full words always skip the read; with RMW off every store does.
  assign go_write = (bus.req_wstrb == 4'hF) ||
                    ((RMW_ENABLE == 0) && (bus.req_wstrb != 4'h0));
  assign is_store = (wstrb_q != 4'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      lat_cnt <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      wen_q   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr[31:2];
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
            ready_q <= 1'b0;
            if (go_write) begin
              state  <= WR;
              resp_q <= 1'b1;
              wen_q  <= (RMW_ENABLE != 0) ? 4'hF : bus.req_wstrb;
            end else begin
              state   <= RD_WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state  <= RD_DONE;
            resp_q <= 1'b1;
            wen_q  <= is_store ? 4'hF : 4'h0;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RD_DONE, WR: begin
          state   <= IDLE;
          resp_q  <= 1'b0;
          wen_q   <= 4'h0;
          ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is only valid during RD_DONE, so the merge stays combinational.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : bus.mem_read_data[8*i +: 8];
    end
  end

  assign bus.req_ready        = ready_q;
  assign bus.resp_valid       = resp_q;
  assign bus.mem_write_enable = wen_q;
  assign bus.mem_address      = {addr_q, 2'b00};
  assign bus.mem_write_data   = (state == WR) ? wdata_q :
                                ((state == RD_DONE) && is_store) ? merged : 32'h0;
  assign bus.resp_rdata       = ((state == RD_DONE) && !is_store) ? bus.mem_read_data : 32'h0;
endmodule

// File: doc/mem_rmw_adapter.md
Name: mem_rmw_adapter

Overview:
- Sits between the core's load/store port and the memory_map block.
- Turns every sub-word store (byte-enable not 4'hF) into a read-modify-write sequence, so the memory side only ever sees whole-word writes.
- Sequences loads against the synchronous memory read latency and returns one response per request.
- Full-word stores pass through in a single write cycle.

Parameters:
- READ_LATENCY, 1: clock edges from mem_address presentation to valid mem_read_data; legal range 1..4.
- RMW_ENABLE, 1: 1 = sub-word stores use read-modify-write; 0 = write_enable strobes pass through unchanged in one write cycle.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core request present
- req_ready  output  1  adapter accepts request this cycle
- req_addr  input  32  byte address (addr_t)
- req_wdata  input  32  lane-positioned store data (data_t)
- req_wstrb  input  4  byte enables; 4'h0 = load
- resp_valid  output  1  one-cycle completion pulse, no backpressure
- resp_rdata  output  32  load data, whole word; 0 for stores
- mem_address  output  32  word-aligned address to memory_map: {addr_q[31:2],2'b00}
- mem_write_data  output  32  whole-word write data
- mem_write_enable  output  4  4'h0 or 4'hF only when RMW_ENABLE=1
- mem_read_data  input  32  registered read data from memory_map

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; addr_q, wdata_q, wstrb_q and lat_cnt = 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, mem_write_enable=0, mem_address=0, mem_write_data=0.
- Reset mid-operation aborts the transaction: no write is issued and no response is given. A write-cycle edge coincident with reset assertion is not performed.
- States: IDLE, RD_WAIT, RD_DONE, WR.
- IDLE:
  - req_ready=1.
  - On req_valid, capture addr/wdata/wstrb.
  - Next state:
    - wstrb==0: RD_WAIT.
    - wstrb==4'hF, or RMW_ENABLE=0 with nonzero wstrb: WR.
    - Otherwise: RD_WAIT.
  - Entering RD_WAIT loads lat_cnt=READ_LATENCY-1.
- RD_WAIT:
  - mem_address driven from addr_q, mem_write_enable=0.
  - If lat_cnt==0, go to RD_DATA; otherwise decrement lat_cnt.
- RD_DATA (the RD_DONE state):
  - mem_read_data is valid in this cycle.
  - Load: resp_valid=1, resp_rdata=mem_read_data, then IDLE.
  - Partial store:
    - mem_write_data lane i = wstrb_q[i] ? wdata_q lane i : mem_read_data lane i (combinational merge).
    - mem_write_enable=4'hF, resp_valid=1, resp_rdata=0, then IDLE.
- WR:
  - mem_write_data=wdata_q.
  - mem_write_enable=4'hF, or wstrb_q when RMW_ENABLE=0.
  - resp_valid=1, then IDLE.
- req_ready=0 in every state except IDLE; requests presented while busy are held by the core, not dropped.
- mem_write_enable is nonzero only in the single WR or store-RD_DATA cycle: exactly one memory write per store.
- Latency, request edge to resp_valid:
  - Load: READ_LATENCY+1 cycles.
  - Partial store: READ_LATENCY+1 cycles.
  - Full store: 1 cycle.
  - Next request is accepted in the cycle after resp_valid.
- req_addr[1:0] are ignored for memory addressing; lane placement comes from wstrb only.
- Non-contiguous strobes (e.g. 4'b0101) merge per byte; no error is raised.
- MMIO addresses (e.g. LEDR at 32'h10000000) get the same treatment: RMW on LEDR reads {22'b0,LEDR} and merges.
- mem_address holds addr_q in all non-IDLE states; in IDLE it holds the last value (no glitch requirement).

Test Plan:
- Load: M[4]=32'h11223344; req addr 32'h10, wstrb 0 -> resp_valid exactly 2 cycles after accept (READ_LATENCY=1), resp_rdata=32'h11223344, no write pulse.
- Byte store: M[4]=32'h11223344; store addr 32'h12, wdata 32'h00AB0000, wstrb 4'b0100 -> one write of 32'h11AB3344 with enable 4'hF; a following load returns 32'h11AB3344.
- Full store: wstrb 4'hF, wdata 32'hDEADBEEF, addr 32'h20 -> write in WR cycle 1 after accept, resp_valid same cycle, M[8]=32'hDEADBEEF.
- Back-to-back with backpressure: issue a store then a load while req_valid is held high -> req_ready low for busy cycles; load accepted the cycle after the store's resp_valid; load returns the stored data.
- Reset in RD_WAIT: READ_LATENCY=3; assert reset_n=0 one cycle after accepting a half-word store -> no mem_write_enable pulse, resp_valid stays 0, req_ready=1 immediately, memory unchanged.
- RMW_ENABLE=0: store wstrb 4'b0011, wdata 32'h0000CAFE -> single cycle, mem_write_enable=4'b0011, no read phase.
